// File: rtl/bcd_entry_display.sv
// Digit-at-a-time signed BCD reading entry with a serial signed difference against the
// previous reading, driving DIGITS+1 seven-segment code/enable positions (top one is sign).
module bcd_entry_display #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned FLASH_DIV = 25000000,
  parameter int unsigned DWELL_DIV = 50000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enter,
  input  logic [3:0]                  digit_in,
  input  logic                        sign_in,
  output logic [4*(DIGITS+1)-1:0]     disp_code,
  output logic [DIGITS:0]             disp_en,
  output logic [$clog2(DIGITS+1)-1:0] entry_idx,
  output logic [4*DIGITS-1:0]         cur_bcd,
  output logic                        cur_neg,
  output logic [4*DIGITS-1:0]         diff_bcd,
  output logic                        diff_neg,
  output logic                        diff_ovf,
  output logic                        diff_valid,
  output logic                        view
);
  localparam int unsigned IW = $clog2(DIGITS + 1);
  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned FW = $clog2(FLASH_DIV + 1);
  localparam int unsigned VW = $clog2(DWELL_DIV + 1);
  localparam logic [3:0] CodeMinus = 4'hA;
  localparam logic [3:0] CodeBlank = 4'hF;

  typedef enum logic [1:0] {StEntry, StCompute, StShow} state_e;
  state_e r_state, w_state_next;

  logic                    r_sync1, r_sync2, r_sync3;
  logic                    w_press, w_digit_ok, w_last, w_commit;
  logic [IW-1:0]           r_idx, r_dig;
  logic [DW-1:0]           r_entry, w_entry_new, r_cur, r_prev, r_acc, w_acc_next, r_diff;
  logic                    r_cur_neg, r_prev_neg, r_diff_neg, r_diff_ovf, r_diff_valid;
  logic                    r_view, r_carry, r_flash;
  logic [FW-1:0]           r_flash_cnt;
  logic [VW-1:0]           r_dwell;
  logic                    w_add, w_cur_ge, w_cout, w_ovf, w_zero, w_neg;
  logic [DW-1:0]           w_big, w_small;
  logic [3:0]              w_a, w_b;
  logic [4:0]              w_sum;
  logic [4*(DIGITS+1)-1:0] r_disp_code, w_disp_code;
  logic [DIGITS:0]         r_disp_en, w_disp_en;

  assign w_press    = r_sync2 & ~r_sync3;
  assign w_digit_ok = digit_in <= 4'd9;
  assign w_last     = r_idx == IW'(DIGITS - 1);
  assign w_commit   = (r_state == StEntry) && w_press && w_digit_ok && w_last;

  // Entry position 0 is the MSD, so it lands in the top magnitude nibble.
  always_comb begin
    w_entry_new = r_entry;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (int'(DIGITS) - 1 - i == int'(r_idx)) w_entry_new[4*i +: 4] = digit_in;
    end
  end

  // Signed-magnitude difference: operands ordered so subtraction never borrows out.
  assign w_add    = r_cur_neg ^ r_prev_neg;
  assign w_cur_ge = r_cur >= r_prev;
  assign w_big    = (w_add || w_cur_ge) ? r_cur : r_prev;
  assign w_small  = (w_add || w_cur_ge) ? r_prev : r_cur;

  always_comb begin
    w_a        = '0;
    w_b        = '0;
    w_cout     = 1'b0;
    w_sum      = '0;
    w_acc_next = r_acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i == int'(r_dig)) begin
        w_a = w_big[4*i +: 4];
        w_b = w_small[4*i +: 4];
      end
    end
    if (w_add) begin
      w_sum = {1'b0, w_a} + {1'b0, w_b} + {4'b0, r_carry};
      if (w_sum > 5'd9) begin
        w_cout = 1'b1;
        w_sum  = w_sum - 5'd10;
      end
    end else begin
      w_sum = {1'b0, w_a} - {1'b0, w_b} - {4'b0, r_carry};
      if (w_sum[4]) begin
        w_cout = 1'b1;
        w_sum  = w_sum + 5'd10;
      end
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i == int'(r_dig)) w_acc_next[4*i +: 4] = w_sum[3:0];
    end
  end

  assign w_ovf  = w_add & r_carry;
  assign w_zero = (r_acc == '0) & ~w_ovf;
  assign w_neg  = ~w_zero & (w_add ? r_cur_neg : (w_cur_ge ? r_cur_neg : ~r_cur_neg));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEntry:   if (w_commit) w_state_next = StCompute;
      StCompute: if (r_dig == IW'(DIGITS)) w_state_next = StShow;
      StShow:    if (w_press) w_state_next = StEntry;
      default:   w_state_next = StEntry;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StEntry;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_disp_code = r_disp_code;
    w_disp_en   = r_disp_en;
    unique case (r_state)
      StEntry: begin
        w_disp_en = '1;
        w_disp_code[4*DIGITS +: 4] = sign_in ? CodeMinus : CodeBlank;
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (int'(DIGITS) - 1 - i == int'(r_idx)) begin
            w_disp_code[4*i +: 4] = digit_in;
            w_disp_en[i]          = r_flash;
          end else if (int'(DIGITS) - 1 - i < int'(r_idx)) begin
            w_disp_code[4*i +: 4] = r_entry[4*i +: 4];
          end else begin
            w_disp_code[4*i +: 4] = CodeBlank;
          end
        end
      end
      StShow: begin
        w_disp_en = '1;
        if (!r_view) begin
          w_disp_code[4*DIGITS +: 4] = r_cur_neg ? CodeMinus : CodeBlank;
          w_disp_code[DW-1:0]        = r_cur;
        end else begin
          w_disp_code[4*DIGITS +: 4] = r_diff_neg ? CodeMinus : CodeBlank;
          w_disp_code[DW-1:0]        = r_diff_ovf ? {DIGITS{CodeMinus}} : r_diff;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_idx        <= '0;
      r_dig        <= '0;
      r_entry      <= '0;
      r_cur        <= '0;
      r_prev       <= '0;
      r_acc        <= '0;
      r_diff       <= '0;
      r_cur_neg    <= 1'b0;
      r_prev_neg   <= 1'b0;
      r_diff_neg   <= 1'b0;
      r_diff_ovf   <= 1'b0;
      r_diff_valid <= 1'b0;
      r_view       <= 1'b0;
      r_carry      <= 1'b0;
      r_flash      <= 1'b1;
      r_flash_cnt  <= '0;
      r_dwell      <= '0;
      r_disp_code  <= '1;
      r_disp_en    <= '1;
    end else begin
      r_sync1      <= enter;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_diff_valid <= 1'b0;
      r_disp_code  <= w_disp_code;
      r_disp_en    <= w_disp_en;
      if (r_flash_cnt == FW'(FLASH_DIV - 1)) begin
        r_flash_cnt <= '0;
        r_flash     <= ~r_flash;
      end else begin
        r_flash_cnt <= r_flash_cnt + FW'(1);
      end
      unique case (r_state)
        StEntry: begin
          if (w_press && w_digit_ok) begin
            r_entry <= w_entry_new;
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
              r_prev     <= r_cur;
              r_prev_neg <= r_cur_neg;
              r_cur      <= w_entry_new;
              r_cur_neg  <= sign_in;
              r_dig      <= '0;
              r_carry    <= 1'b0;
              r_acc      <= '0;
            end
          end
        end
        StCompute: begin
          if (r_dig == IW'(DIGITS)) begin
            r_diff       <= w_ovf ? {DIGITS{4'h9}} : r_acc;
            r_diff_neg   <= w_neg;
            r_diff_ovf   <= w_ovf;
            r_diff_valid <= 1'b1;
            r_view       <= 1'b0;
            r_dwell      <= '0;
          end else begin
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_dig   <= r_dig + IW'(1);
          end
        end
        StShow: begin
          // A key press takes priority over a dwell expiry on the same cycle.
          if (w_press) begin
            r_idx   <= '0;
            r_entry <= '0;
          end else if (r_dwell == VW'(DWELL_DIV - 1)) begin
            r_view  <= ~r_view;
            r_dwell <= '0;
          end else begin
            r_dwell <= r_dwell + VW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_code  = r_disp_code;
  assign disp_en    = r_disp_en;
  assign entry_idx  = r_idx;
  assign cur_bcd    = r_cur;
  assign cur_neg    = r_cur_neg;
  assign diff_bcd   = r_diff;
  assign diff_neg   = r_diff_neg;
  assign diff_ovf   = r_diff_ovf;
  assign diff_valid = r_diff_valid;
  assign view       = r_view;

endmodule

// File: tb/tb_bcd_entry_display.sv
// Bench for bcd_entry_display: directed and random readings checked against an
// integer-arithmetic reference of the signed difference and display contents.
module tb_bcd_entry_display;
  localparam int D   = 3;
  localparam int FD  = 4;
  localparam int DWL = 16;

  logic             clk = 1'b0;
  logic             rst, enter, sign_in;
  logic [3:0]       digit_in;
  logic [4*(D+1)-1:0] disp_code;
  logic [D:0]       disp_en;
  logic [1:0]       entry_idx;
  logic [4*D-1:0]   cur_bcd, diff_bcd;
  logic             cur_neg, diff_neg, diff_ovf, diff_valid, view;

  int n_pass  = 0;
  int n_total = 0;

  int m_cur_mag  = 0;
  bit m_cur_neg  = 1'b0;
  int m_diff_mag = 0;
  bit m_diff_neg = 1'b0;
  bit m_diff_ovf = 1'b0;
  bit m_in_show  = 1'b0;

  always #5 clk = ~clk;

  bcd_entry_display #(.DIGITS(D), .FLASH_DIV(FD), .DWELL_DIV(DWL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .digit_in   (digit_in),
    .sign_in    (sign_in),
    .disp_code  (disp_code),
    .disp_en    (disp_en),
    .entry_idx  (entry_idx),
    .cur_bcd    (cur_bcd),
    .cur_neg    (cur_neg),
    .diff_bcd   (diff_bcd),
    .diff_neg   (diff_neg),
    .diff_ovf   (diff_ovf),
    .diff_valid (diff_valid),
    .view       (view)
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100 % 10);
    t = 4'(v / 10 % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [15:0] exp_view0();
    return {(m_cur_neg ? 4'hA : 4'hF), to_bcd(m_cur_mag)};
  endfunction

  function automatic logic [15:0] exp_view1();
    logic [11:0] mag;
    mag = m_diff_ovf ? 12'hAAA : to_bcd(m_diff_mag);
    return {(m_diff_neg ? 4'hA : 4'hF), mag};
  endfunction

  task automatic model_commit(input int mag, input bit neg);
    int prev_val, diff;
    prev_val   = m_cur_neg ? -m_cur_mag : m_cur_mag;
    m_cur_mag  = mag;
    m_cur_neg  = neg;
    diff       = (neg ? -mag : mag) - prev_val;
    m_diff_neg = diff < 0;
    m_diff_mag = (diff < 0) ? -diff : diff;
    m_diff_ovf = m_diff_mag > 999;
    if (m_diff_ovf) m_diff_mag = 999;
  endtask

  task automatic model_reset();
    m_cur_mag  = 0;
    m_cur_neg  = 1'b0;
    m_diff_mag = 0;
    m_diff_neg = 1'b0;
    m_diff_ovf = 1'b0;
    m_in_show  = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    enter    = 1'b1;
    repeat (4) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Enters a full reading and checks commit-to-valid latency and the results.
  task automatic do_reading(input string nm, input int mag, input bit neg);
    int  cnt;
    bit  seen;
    sign_in = neg;
    if (m_in_show) begin
      press(4'd0);
      n_total++;
      if (entry_idx !== 2'd0) $display("FAIL %s wake_idx got=%0d exp=0", nm, entry_idx);
      else n_pass++;
    end
    press(4'(mag / 100));
    press(4'(mag / 10 % 10));
    @(negedge clk);
    digit_in = 4'(mag % 10);
    enter    = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (entry_idx == 2'd3) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen) $display("FAIL %s commit_idx got=%0d exp=3", nm, entry_idx);
    else n_pass++;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (diff_valid === 1'b1) begin
        cnt = k;
        break;
      end
    end
    model_commit(mag, neg);
    n_total++;
    if (cnt != D + 1) $display("FAIL %s valid_latency got=%0d exp=%0d", nm, cnt, D + 1);
    else n_pass++;
    n_total++;
    if (cur_bcd !== to_bcd(m_cur_mag) || cur_neg !== m_cur_neg)
      $display("FAIL %s cur got=%h/%b exp=%h/%b", nm, cur_bcd, cur_neg,
               to_bcd(m_cur_mag), m_cur_neg);
    else n_pass++;
    n_total++;
    if (diff_bcd !== to_bcd(m_diff_mag) || diff_neg !== m_diff_neg || diff_ovf !== m_diff_ovf)
      $display("FAIL %s diff got=%h/%b/%b exp=%h/%b/%b", nm, diff_bcd, diff_neg, diff_ovf,
               to_bcd(m_diff_mag), m_diff_neg, m_diff_ovf);
    else n_pass++;
    @(negedge clk);
    enter     = 1'b0;
    m_in_show = 1'b1;
    n_total++;
    if (diff_valid !== 1'b0 || view !== 1'b0 || disp_code !== exp_view0() || disp_en !== 4'hF)
      $display("FAIL %s show_view0 got=%b/%b/%h/%h exp=0/0/%h/f", nm, diff_valid, view,
               disp_code, disp_en, exp_view0());
    else n_pass++;
  endtask

  task automatic check_view1(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (view === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    n_total++;
    if (!seen || disp_code !== exp_view1() || disp_en !== 4'hF)
      $display("FAIL %s view1_disp got=%b/%h/%h exp=1/%h/f", nm, seen, disp_code, disp_en,
               exp_view1());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enter = 1'b0; sign_in = 1'b0; digit_in = 4'd6;
    repeat (3) @(negedge clk);
    n_total++;
    if (entry_idx !== 2'd0 || cur_bcd !== 12'h000 || cur_neg !== 1'b0 || diff_bcd !== 12'h000 ||
        diff_neg !== 1'b0 || diff_ovf !== 1'b0 || diff_valid !== 1'b0 || view !== 1'b0)
      $display("FAIL reset_regs got=%0d/%h/%b/%h/%b/%b/%b/%b exp=all zero", entry_idx, cur_bcd,
               cur_neg, diff_bcd, diff_neg, diff_ovf, diff_valid, view);
    else n_pass++;
    n_total++;
    if (disp_code !== 16'hFFFF || disp_en !== 4'hF)
      $display("FAIL reset_disp got=%h/%h exp=ffff/f", disp_code, disp_en);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (disp_code !== 16'hF6FF) $display("FAIL entry_disp got=%h exp=f6ff", disp_code);
    else n_pass++;
  endtask

  task automatic test_entry_commit();
    do_reading("commit_125", 125, 1'b0);
  endtask

  task automatic test_same_sign();
    do_reading("same_sign_080", 80, 1'b0);
    repeat (14) @(negedge clk);
    n_total++;
    if (view !== 1'b0) $display("FAIL dwell_early got=%b exp=0", view);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (view !== 1'b1) $display("FAIL dwell_16 got=%b exp=1", view);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (disp_code !== exp_view1()) $display("FAIL diff_disp got=%h exp=%h", disp_code, exp_view1());
    else n_pass++;
    repeat (15) @(negedge clk);
    n_total++;
    if (view !== 1'b0) $display("FAIL dwell_32 got=%b exp=0", view);
    else n_pass++;
  endtask

  task automatic test_opposite_signs();
    do_reading("opp_030", 30, 1'b0);
    do_reading("opp_m050", 50, 1'b1);
    check_view1("opp_m050");
    do_reading("opp_500", 500, 1'b0);
  endtask

  task automatic test_overflow_zero();
    do_reading("ovf_m050", 50, 1'b1);
    do_reading("ovf_999", 999, 1'b0);
    check_view1("ovf_999");
    do_reading("zero_200a", 200, 1'b0);
    do_reading("zero_200b", 200, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      do_reading("random", int'($urandom_range(0, 999)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_entry_edge();
    logic s[12];
    int   errs;
    press(4'd0);
    press(4'd12);
    n_total++;
    if (entry_idx !== 2'd0) $display("FAIL bad_digit_idx got=%0d exp=0", entry_idx);
    else n_pass++;
    @(negedge clk);
    digit_in = 4'd7;
    enter    = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (disp_code[11:4] !== 8'h77 || disp_en[2] !== 1'b1 || disp_code[3:0] !== 4'hF)
      $display("FAIL held_disp got=%h/%h exp=x77f/1xx", disp_code, disp_en);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      s[i] = disp_en[1];
      @(negedge clk);
    end
    errs = 0;
    for (int i = 0; i < 8; i++) if (s[i + 4] === s[i]) errs++;
    n_total++;
    if (errs != 0) $display("FAIL flash_period got=%0d bad samples exp=0", errs);
    else n_pass++;
    repeat (68) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (entry_idx !== 2'd1) $display("FAIL held_idx got=%0d exp=1", entry_idx);
    else n_pass++;
  endtask

  task automatic test_reset_mid_compute();
    int hits;
    bit seen;
    do_reset();
    sign_in = 1'b1;
    press(4'd4);
    press(4'd2);
    @(negedge clk);
    digit_in = 4'd1;
    enter    = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (entry_idx == 2'd3) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (!seen || entry_idx !== 2'd0 || cur_bcd !== 12'h000 || cur_neg !== 1'b0 ||
        diff_bcd !== 12'h000 || diff_valid !== 1'b0 || view !== 1'b0 ||
        disp_code !== 16'hFFFF || disp_en !== 4'hF)
      $display("FAIL mid_reset got=%b/%0d/%h/%b/%h/%b/%b/%h/%h exp=1/0/000/0/000/0/0/ffff/f",
               seen, entry_idx, cur_bcd, cur_neg, diff_bcd, diff_valid, view, disp_code, disp_en);
    else n_pass++;
    enter = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (diff_valid !== 1'b0) hits++;
    end
    n_total++;
    if (hits != 0) $display("FAIL no_valid_after_reset got=%0d pulses exp=0", hits);
    else n_pass++;
    press(4'd5);
    n_total++;
    if (entry_idx !== 2'd1) $display("FAIL restart_idx got=%0d exp=1", entry_idx);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_entry_commit();
    test_same_sign();
    test_opposite_signs();
    test_overflow_zero();
    test_random();
    test_entry_edge();
    test_reset_mid_compute();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
